// File: rtl/spcpu_alu_and_decoders.sv
// Registered ALU and front-end instruction decoder for the spcpu core.
// Decode and ALU are combinational; every output is registered once.
module spcpu_alu_and_decoders (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr_hi,
    input  logic [3:0]  alu_oper,
    input  logic [7:0]  alu_a_hi,
    input  logic [7:0]  alu_a_lo,
    input  logic [7:0]  alu_b,
    input  logic [3:0]  proc_flags_in,
    output logic [2:0]  group_out,
    output logic        instr_is_32_bit,
    output logic        ig1_valid,
    output logic [2:0]  ig1_opcode,
    output logic [3:0]  ig1_ra_index,
    output logic [7:0]  ig1_imm8,
    output logic [3:0]  ig1_alu_oper,
    output logic        ig1_changes_pc,
    output logic [7:0]  alu_out_hi,
    output logic [7:0]  alu_out_lo,
    output logic [3:0]  proc_flags_out
);

    logic [2:0] group_d, group_q;
    logic       is32_d, is32_q;
    logic       valid_d, valid_q;
    logic [2:0] opc_d, opc_q;
    logic [3:0] ra_d, ra_q;
    logic [7:0] imm_d, imm_q;
    logic [3:0] ig1op_d, ig1op_q;
    logic       cpc_d, cpc_q;
    logic [7:0] hi_d, hi_q;
    logic [7:0] lo_d, lo_q;
    logic [3:0] flags_d, flags_q;

    always_comb begin
        casez (instr_hi[15:11])
            5'b0????: group_d = 3'd1;
            5'b10???: group_d = 3'd2;
            5'b110??: group_d = 3'd3;
            5'b1110?: group_d = 3'd4;
            5'b11110: group_d = 3'd5;
            default:  group_d = 3'd0;
        endcase
    end

    assign is32_d  = (group_d == 3'd5);
    assign valid_d = (group_d == 3'd1);
    assign opc_d   = instr_hi[14:12];
    assign ra_d    = instr_hi[11:8];
    assign imm_d   = instr_hi[7:0];
    assign ig1op_d = (opc_d == 3'd7) ? 4'd13 : {1'b0, opc_d};
    // r14:r15 form the PC; cmpi never writes its destination
    assign cpc_d   = valid_d && (ra_d[3:1] == 3'b111) && (opc_d != 3'd4);

    logic       cin;
    logic [2:0] n;
    logic [8:0] add_s, sub_s;
    logic [7:0] lsl_r, lsr_r, asr_r;
    logic [15:0] rol_w, ror_w, b_sx, add16, sub16;

    assign cin   = proc_flags_in[1];
    assign n     = alu_b[2:0];
    assign add_s = {1'b0, alu_a_lo} + {1'b0, alu_b}
                 + {8'd0, alu_oper[0] & cin};
    assign sub_s = {1'b0, alu_a_lo} + {1'b0, ~alu_b}
                 + {8'd0, (alu_oper == 4'd3) ? cin : 1'b1};
    assign lsl_r = alu_a_lo << n;
    assign lsr_r = alu_a_lo >> n;
    assign asr_r = $signed(alu_a_lo) >>> n;
    assign rol_w = {alu_a_lo, alu_a_lo} << n;
    assign ror_w = {alu_a_lo, alu_a_lo} >> n;
    assign b_sx  = {{8{alu_b[7]}}, alu_b};
    assign add16 = {alu_a_hi, alu_a_lo} + b_sx;
    assign sub16 = {alu_a_hi, alu_a_lo} - b_sx;

    logic [7:0] res;
    logic       fz, fc, fv, fn, upd_nz;

    always_comb begin
        hi_d   = alu_a_hi;
        lo_d   = alu_a_lo;
        res    = alu_a_lo;
        fz     = proc_flags_in[0];
        fc     = proc_flags_in[1];
        fv     = proc_flags_in[2];
        fn     = proc_flags_in[3];
        upd_nz = 1'b0;
        case (alu_oper)
            4'd0, 4'd1: begin
                res    = add_s[7:0];
                lo_d   = res;
                fc     = add_s[8];
                fv     = (alu_a_lo[7] == alu_b[7])
                      && (res[7] != alu_a_lo[7]);
                upd_nz = 1'b1;
            end
            4'd2, 4'd3, 4'd4: begin
                res    = sub_s[7:0];
                lo_d   = (alu_oper == 4'd4) ? alu_a_lo : res;
                fc     = sub_s[8];
                fv     = (alu_a_lo[7] != alu_b[7])
                      && (res[7] != alu_a_lo[7]);
                upd_nz = 1'b1;
            end
            4'd5: begin
                res    = alu_a_lo & alu_b;
                lo_d   = res;
                upd_nz = 1'b1;
            end
            4'd6: begin
                res    = alu_a_lo | alu_b;
                lo_d   = res;
                upd_nz = 1'b1;
            end
            4'd7: begin
                res    = alu_a_lo ^ alu_b;
                lo_d   = res;
                upd_nz = 1'b1;
            end
            4'd8: begin
                res    = lsl_r;
                lo_d   = res;
                // 8-n taken modulo 8 still picks the right bit for n=1..7
                if (n != 3'd0) fc = alu_a_lo[3'd0 - n];
                upd_nz = 1'b1;
            end
            4'd9, 4'd10: begin
                res    = (alu_oper == 4'd9) ? lsr_r : asr_r;
                lo_d   = res;
                if (n != 3'd0) fc = alu_a_lo[n - 3'd1];
                upd_nz = 1'b1;
            end
            4'd11: begin
                res    = rol_w[15:8];
                lo_d   = res;
                upd_nz = 1'b1;
            end
            4'd12: begin
                res    = ror_w[7:0];
                lo_d   = res;
                upd_nz = 1'b1;
            end
            4'd13: lo_d = alu_b;
            4'd14: {hi_d, lo_d} = add16;
            default: {hi_d, lo_d} = sub16;
        endcase
        if (upd_nz) begin
            fz = (res == 8'd0);
            fn = res[7];
        end
        flags_d = {fn, fv, fc, fz};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            group_q <= '0;
            is32_q  <= 1'b0;
            valid_q <= 1'b0;
            opc_q   <= '0;
            ra_q    <= '0;
            imm_q   <= '0;
            ig1op_q <= '0;
            cpc_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            flags_q <= '0;
        end else begin
            group_q <= group_d;
            is32_q  <= is32_d;
            valid_q <= valid_d;
            opc_q   <= opc_d;
            ra_q    <= ra_d;
            imm_q   <= imm_d;
            ig1op_q <= ig1op_d;
            cpc_q   <= cpc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            flags_q <= flags_d;
        end
    end

    assign group_out       = group_q;
    assign instr_is_32_bit = is32_q;
    assign ig1_valid       = valid_q;
    assign ig1_opcode      = opc_q;
    assign ig1_ra_index    = ra_q;
    assign ig1_imm8        = imm_q;
    assign ig1_alu_oper    = ig1op_q;
    assign ig1_changes_pc  = cpc_q;
    assign alu_out_hi      = hi_q;
    assign alu_out_lo      = lo_q;
    assign proc_flags_out  = flags_q;

endmodule

// File: tb/tb_spcpu_alu_and_decoders.sv
// Directed self-checking bench for spcpu_alu_and_decoders.
// Each task drives its own vectors and compares against hand-computed values.
module tb_spcpu_alu_and_decoders;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instr_hi = '0;
    logic [3:0]  alu_oper = '0;
    logic [7:0]  alu_a_hi = '0;
    logic [7:0]  alu_a_lo = '0;
    logic [7:0]  alu_b = '0;
    logic [3:0]  proc_flags_in = '0;
    logic [2:0]  group_out;
    logic        instr_is_32_bit;
    logic        ig1_valid;
    logic [2:0]  ig1_opcode;
    logic [3:0]  ig1_ra_index;
    logic [7:0]  ig1_imm8;
    logic [3:0]  ig1_alu_oper;
    logic        ig1_changes_pc;
    logic [7:0]  alu_out_hi;
    logic [7:0]  alu_out_lo;
    logic [3:0]  proc_flags_out;

    int tests = 0;
    int fails = 0;

    spcpu_alu_and_decoders dut (
        .clk(clk),
        .reset(reset),
        .instr_hi(instr_hi),
        .alu_oper(alu_oper),
        .alu_a_hi(alu_a_hi),
        .alu_a_lo(alu_a_lo),
        .alu_b(alu_b),
        .proc_flags_in(proc_flags_in),
        .group_out(group_out),
        .instr_is_32_bit(instr_is_32_bit),
        .ig1_valid(ig1_valid),
        .ig1_opcode(ig1_opcode),
        .ig1_ra_index(ig1_ra_index),
        .ig1_imm8(ig1_imm8),
        .ig1_alu_oper(ig1_alu_oper),
        .ig1_changes_pc(ig1_changes_pc),
        .alu_out_hi(alu_out_hi),
        .alu_out_lo(alu_out_lo),
        .proc_flags_out(proc_flags_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [48:0] all;
        instr_hi = 16'h3E05; alu_oper = 4'd0;
        alu_a_hi = 8'hAB; alu_a_lo = 8'hFF;
        alu_b = 8'h01; proc_flags_in = 4'hF;
        reset = 1'b1;
        step();
        all = {group_out, instr_is_32_bit, ig1_valid, ig1_opcode,
               ig1_ra_index, ig1_imm8, ig1_alu_oper, ig1_changes_pc,
               alu_out_hi, alu_out_lo, proc_flags_out};
        tests++;
        if (all !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0", all);
        end
        reset = 1'b0;
        proc_flags_in = 4'h0;
        step();
        tests++;
        if ({group_out, alu_out_hi, alu_out_lo, proc_flags_out}
            !== {3'd1, 8'hAB, 8'h00, 4'b0011}) begin
            fails++;
            $display("FAIL reset_release: got g=%0d %h%h f=%b want g=1 AB00 f=0011",
                     group_out, alu_out_hi, alu_out_lo, proc_flags_out);
        end
    endtask

    task automatic test_group1();
        logic [22:0] got;
        instr_hi = 16'h3E05;
        step();
        got = {group_out, ig1_valid, ig1_opcode, ig1_ra_index,
               ig1_imm8, ig1_alu_oper, ig1_changes_pc};
        tests++;
        if (got !== {3'd1, 1'b1, 3'd3, 4'd14, 8'h05, 4'd3, 1'b1}) begin
            fails++;
            $display("FAIL g1_sbci_r14: got %h want %h", got,
                     {3'd1, 1'b1, 3'd3, 4'd14, 8'h05, 4'd3, 1'b1});
        end
        instr_hi = 16'h4E05;
        step();
        tests++;
        if ({ig1_alu_oper, ig1_changes_pc} !== {4'd4, 1'b0}) begin
            fails++;
            $display("FAIL g1_cmpi_r14: got op=%0d pc=%b want op=4 pc=0",
                     ig1_alu_oper, ig1_changes_pc);
        end
        instr_hi = 16'h7F12;
        step();
        got = {group_out, ig1_valid, ig1_opcode, ig1_ra_index,
               ig1_imm8, ig1_alu_oper, ig1_changes_pc};
        tests++;
        if (got !== {3'd1, 1'b1, 3'd7, 4'd15, 8'h12, 4'd13, 1'b1}) begin
            fails++;
            $display("FAIL g1_cpyi_r15: got %h want %h", got,
                     {3'd1, 1'b1, 3'd7, 4'd15, 8'h12, 4'd13, 1'b1});
        end
        instr_hi = 16'h0D00;
        step();
        tests++;
        if (ig1_changes_pc !== 1'b0) begin
            fails++;
            $display("FAIL g1_addi_r13: got pc=%b want 0", ig1_changes_pc);
        end
    endtask

    task automatic test_groups();
        logic [15:0] ins [6];
        logic [5:0]  exp [6];
        logic [5:0]  got;
        ins[0] = 16'h8000; exp[0] = {3'd2, 1'b0, 1'b0, 1'b0};
        ins[1] = 16'hC000; exp[1] = {3'd3, 1'b0, 1'b0, 1'b0};
        ins[2] = 16'hE000; exp[2] = {3'd4, 1'b0, 1'b0, 1'b0};
        ins[3] = 16'hF000; exp[3] = {3'd5, 1'b1, 1'b0, 1'b0};
        ins[4] = 16'hF800; exp[4] = {3'd0, 1'b0, 1'b0, 1'b0};
        ins[5] = 16'hFE00; exp[5] = {3'd0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            instr_hi = ins[i];
            step();
            got = {group_out, instr_is_32_bit, ig1_valid, ig1_changes_pc};
            tests++;
            if (got !== exp[i]) begin
                fails++;
                $display("FAIL group_%h: got %b want %b", ins[i], got, exp[i]);
            end
        end
    endtask

    task automatic test_alu();
        // {oper, a_hi, a_lo, b, flags_in, exp_hi, exp_lo, exp_flags}
        logic [51:0] v [18];
        logic [19:0] got;
        v[0]  = {4'd0,  8'hAB, 8'hFF, 8'h01, 4'b0000, 8'hAB, 8'h00, 4'b0011};
        v[1]  = {4'd2,  8'h00, 8'h80, 8'h01, 4'b0000, 8'h00, 8'h7F, 4'b0110};
        v[2]  = {4'd1,  8'h00, 8'h7F, 8'h00, 4'b0010, 8'h00, 8'h80, 4'b1100};
        v[3]  = {4'd8,  8'h00, 8'h81, 8'h01, 4'b0000, 8'h00, 8'h02, 4'b0010};
        v[4]  = {4'd14, 8'h12, 8'hFF, 8'hFF, 4'b1010, 8'h12, 8'hFE, 4'b1010};
        v[5]  = {4'd15, 8'h00, 8'h00, 8'h01, 4'b0000, 8'hFF, 8'hFF, 4'b0000};
        v[6]  = {4'd4,  8'h00, 8'h05, 8'h05, 4'b0000, 8'h00, 8'h05, 4'b0011};
        v[7]  = {4'd3,  8'h00, 8'h10, 8'h01, 4'b0000, 8'h00, 8'h0E, 4'b0010};
        v[8]  = {4'd5,  8'h00, 8'hF0, 8'h3C, 4'b0110, 8'h00, 8'h30, 4'b0110};
        v[9]  = {4'd6,  8'h00, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 4'b0001};
        v[10] = {4'd7,  8'h00, 8'hFF, 8'h0F, 4'b0000, 8'h00, 8'hF0, 4'b1000};
        v[11] = {4'd9,  8'h00, 8'h81, 8'h01, 4'b0000, 8'h00, 8'h40, 4'b0010};
        v[12] = {4'd10, 8'h00, 8'h81, 8'h02, 4'b0010, 8'h00, 8'hE0, 4'b1000};
        v[13] = {4'd8,  8'h00, 8'h81, 8'h08, 4'b0010, 8'h00, 8'h81, 4'b1010};
        v[14] = {4'd11, 8'h00, 8'h81, 8'h01, 4'b0000, 8'h00, 8'h03, 4'b0000};
        v[15] = {4'd12, 8'h00, 8'h81, 8'h01, 4'b0000, 8'h00, 8'hC0, 4'b1000};
        v[16] = {4'd13, 8'h77, 8'h00, 8'h5A, 4'b1111, 8'h77, 8'h5A, 4'b1111};
        v[17] = {4'd14, 8'hFF, 8'hFF, 8'h01, 4'b0000, 8'h00, 8'h00, 4'b0000};
        for (int i = 0; i < 18; i++) begin
            {alu_oper, alu_a_hi, alu_a_lo, alu_b, proc_flags_in} = v[i][51:20];
            step();
            got = {alu_out_hi, alu_out_lo, proc_flags_out};
            tests++;
            if (got !== v[i][19:0]) begin
                fails++;
                $display("FAIL alu_vec%0d_op%0d: got %h want %h",
                         i, v[i][51:48], got, v[i][19:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        alu_oper = 4'd0; alu_a_hi = 8'h00; alu_a_lo = 8'h01;
        alu_b = 8'h02; proc_flags_in = 4'b0000;
        instr_hi = 16'h8000;
        step();
        alu_a_lo = 8'h10;
        reset = 1'b1;
        step();
        tests++;
        if ({group_out, alu_out_lo, proc_flags_out} !== '0) begin
            fails++;
            $display("FAIL midstream_reset: got g=%0d lo=%h f=%b want 0",
                     group_out, alu_out_lo, proc_flags_out);
        end
        reset = 1'b0;
        alu_a_lo = 8'h20;
        step();
        tests++;
        if ({group_out, alu_out_lo} !== {3'd2, 8'h22}) begin
            fails++;
            $display("FAIL after_reset_op: got g=%0d lo=%h want g=2 lo=22",
                     group_out, alu_out_lo);
        end
        alu_a_lo = 8'h30;
        instr_hi = 16'hC000;
        step();
        tests++;
        if ({group_out, alu_out_lo} !== {3'd3, 8'h32}) begin
            fails++;
            $display("FAIL b2b_op: got g=%0d lo=%h want g=3 lo=32",
                     group_out, alu_out_lo);
        end
    endtask

    initial begin
        test_reset();
        test_group1();
        test_groups();
        test_alu();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
